lpc_io_target: RTL



---
 rtl/lpc_pkg.sv | 26 ++
 rtl/lpc_io_target_if.sv | 26 ++
 rtl/lpc_sync_timer.sv | 20 ++
 rtl/lpc_io_target.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared constants and state encoding for the LPC I/O-cycle target.
package lpc_pkg;

  localparam logic [3:0] CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] CYC_IO_WR  = 4'b0010;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [3:0] NIB_START  = 4'b0000;
  localparam logic [3:0] NIB_ABORT  = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SYNC,
    ST_RDATA,
    ST_TTAR,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/lpc_io_target_if.sv
// LPC pad signals plus the byte-wide valid/ready register port.
interface lpc_io_target_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  lframe_n;
  logic [3:0]            lad_in;
  logic [3:0]            lad_out;
  logic                  lad_oe;
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wdata;
  logic                  req_ready;
  logic [7:0]            req_rdata;
  logic                  sync_err;

  modport slave (
    input  lframe_n, lad_in, req_ready, req_rdata,
    output lad_out, lad_oe, req_valid, req_write, req_addr, req_wdata, sync_err
  );

  modport master (
    output lframe_n, lad_in, req_ready, req_rdata,
    input  lad_out, lad_oe, req_valid, req_write, req_addr, req_wdata, sync_err
  );
endinterface

// File: rtl/lpc_sync_timer.sv
// Long-wait SYNC counter; only instantiated when LPC_SYNC_TIMEOUT_EN is defined.
module lpc_sync_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic run,
  output logic expired
);
  logic [15:0] cnt;

  assign expired = (cnt == 16'(TIMEOUT_CYCLES));

  // Holds at the limit so the error code lasts exactly one SYNC cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)        cnt <= '0;
    else if (!run)     cnt <= '0;
    else if (!expired) cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O read/write target: decodes a fixed window into single-byte register requests.
// Optional SYNC long-wait timeout is enabled with `define LPC_SYNC_TIMEOUT_EN.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h0A00,
  parameter int          ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            ACLK,
  input  logic            ARESET,
  lpc_io_target_if.slave  bus
);
  state_t                state;
  logic [1:0]            nib;
  logic [11:0]           addr_q;
  logic [7:0]            wdata_q;
  logic [7:0]            rdata_q;
  logic                  frame_write;
  logic                  want;
  logic                  mine;
  logic                  done;
  logic                  expired;

  logic [15:0]           addr_next;
  logic                  addr_hit;
  logic                  issue_evt;
  logic                  accept;
  logic                  tmo;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [7:0]            iss_wdata;

  assign addr_next = {addr_q, bus.lad_in};
  assign addr_hit  = (addr_next[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);
  assign accept    = bus.req_valid && bus.req_ready;
  assign issue_evt = bus.lframe_n &&
                     ((state == ST_ADDR && nib == 2'd3 && addr_hit && !frame_write) ||
                      (state == ST_WDATA && nib == 2'd1));
  assign tmo       = bus.lframe_n && state == ST_SYNC && !done && expired;

`ifdef LPC_SYNC_TIMEOUT_EN
  lpc_sync_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .run     (state == ST_SYNC && !done),
    .expired (expired)
  );
  assign bus.sync_err = (state == ST_SYNC) && !done && expired;
`else
  assign expired      = 1'b0;
  assign bus.sync_err = 1'b0;
`endif

  // Immediate issue takes the nibble on the bus; a deferred issue uses the stored frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    iss_addr  = addr_q[ADDR_WIDTH-1:0];
    iss_wdata = wdata_q;
    if (state == ST_ADDR)  iss_addr  = addr_next[ADDR_WIDTH-1:0];
    if (state == ST_WDATA) iss_wdata = {bus.lad_in, wdata_q[3:0]};
  end

  always_comb begin
    bus.lad_oe  = 1'b0;
    bus.lad_out = NIB_ABORT;
    case (state)
      ST_SYNC: begin
        bus.lad_oe  = 1'b1;
        bus.lad_out = done ? SYNC_READY : (expired ? SYNC_ERR : SYNC_LWAIT);
      end
      ST_RDATA: begin
        bus.lad_oe  = 1'b1;
        bus.lad_out = nib[0] ? rdata_q[7:4] : rdata_q[3:0];
      end
      ST_TTAR:  bus.lad_oe = !nib[0];
      default:  ;
    endcase
  end

  // Any LFRAME# low sample restarts framing; the last low nibble wins.
  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: clocked state uses non-blocking assignments only, so every read sees the pre-edge value.
    if (ARESET) begin
      state       <= ST_IDLE;
      nib         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      frame_write <= 1'b0;
    end else if (!bus.lframe_n) begin
      nib <= '0;
      if (bus.lad_in == NIB_START)      state <= ST_CYCTYPE;
      else if (bus.lad_in == NIB_ABORT) state <= ST_IDLE;
      else                              state <= ST_IGNORE;
    end else begin
      case (state)
        ST_CYCTYPE: begin
          frame_write <= (bus.lad_in == CYC_IO_WR);
          state <= (bus.lad_in == CYC_IO_RD || bus.lad_in == CYC_IO_WR) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: begin
          addr_q <= addr_next[11:0];
          nib    <= nib + 2'd1;
          if (nib == 2'd3)
            state <= !addr_hit ? ST_IGNORE : (frame_write ? ST_WDATA : ST_HTAR);
        end
        ST_WDATA: begin
          nib <= nib + 2'd1;
          if (nib == 2'd0) wdata_q <= {4'h0, bus.lad_in};
          else begin
            wdata_q <= {bus.lad_in, wdata_q[3:0]};
            nib     <= '0;
            state   <= ST_HTAR;
          end
        end
        ST_HTAR: begin
          nib <= nib + 2'd1;
          if (nib[0]) begin nib <= '0; state <= ST_SYNC; end
        end
        ST_SYNC: begin
          nib <= '0;
          if (done)         state <= frame_write ? ST_TTAR : ST_RDATA;
          else if (expired) state <= ST_TTAR;
        end
        ST_RDATA: begin
          nib <= nib + 2'd1;
          if (nib[0]) begin nib <= '0; state <= ST_TTAR; end
        end
        ST_TTAR: begin
          nib <= nib + 2'd1;
          if (nib[0]) begin nib <= '0; state <= ST_IDLE; end
        end
        default: ;
      endcase
    end
  end

  // Request port: 'mine' marks an outstanding request owned by the current frame.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_wdata <= '0;
      want          <= 1'b0;
      mine          <= 1'b0;
      done          <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (accept) begin
        bus.req_valid <= 1'b0;
        if (mine) begin
          done    <= 1'b1;
          rdata_q <= bus.req_rdata;
        end
      end
      if ((issue_evt || (want && bus.lframe_n)) && !bus.req_valid) begin
        bus.req_valid <= 1'b1;
        bus.req_write <= frame_write;
        bus.req_addr  <= iss_addr;
        bus.req_wdata <= iss_wdata;
        want          <= 1'b0;
        mine          <= 1'b1;
        done          <= 1'b0;
      end else if (issue_evt) begin
        want <= 1'b1;
      end
      if (tmo) begin
        bus.req_valid <= 1'b0;
        want          <= 1'b0;
        mine          <= 1'b0;
      end
      if (!bus.lframe_n) begin
        want <= 1'b0;
        mine <= 1'b0;
        done <= 1'b0;
      end
    end
  end
endmodule
